fir_coeff_load_ctrl: RTL and testbench
======================================

Name: fir_coeff_load_ctrl

Overview:
Sequencer that reloads the FIR tap coefficients into the four-bank SPSRAM behind the FIR datapath.
- Accepts a coefficient stream over a valid/ready handshake.
- Drives the filter's coefficient-update flag and the SPSRAM write port (chip-select, write-enable, 6-bit address, 16-bit data).
- Aligns the start of each update to a 600 kHz sample boundary so the filter stops cleanly.
- Replaces hand-driven bench or host sequencing of the RAM write port.

Parameters:
NUM_TAPS, 33, number of coefficients written per load
TAPS_PER_BANK, 10, coefficients per SPSRAM bank (local address 0..TAPS_PER_BANK-1)
NUM_BANKS, 4, SPSRAM banks; bank index = address[5:4]
SETTLE_CYC, 25, clocks the update flag is held before the first write
DATA_W, 16, coefficient width (signed)

Ports:
iClk12M  in  1  12 MHz system clock, the only clock
iRsn  in  1  asynchronous active-low reset
iEnSample600k  in  1  one-cycle 600 kHz sample strobe
iLoadReq  in  1  one-cycle request to start a coefficient load
iAbort  in  1  abandon the load in progress
iCoefValid  in  1  coefficient stream valid
iCoefData  in  DATA_W  signed coefficient, tap order 0..NUM_TAPS-1
oCoefReady  out  1  controller accepts iCoefData this cycle
oCoeffUpdateFlag  out  1  to FIR: 1 = coefficient update phase, 0 = filter operation
oCsnRam  out  1  SPSRAM chip select, active low
oWrnRam  out  1  SPSRAM write enable, active low
oAddrRam  out  6  {bank[1:0], local[3:0]}
oWrDtRam  out  DATA_W  SPSRAM write data
oBusy  out  1  high in every state except IDLE
oDone  out  1  one-cycle pulse: load completed
oAborted  out  1  one-cycle pulse: load abandoned

Behaviour:
- All outputs registered. Reset values: oCoeffUpdateFlag=0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oCoefReady=0, oBusy=0, oDone=0, oAborted=0.
- Reset is asynchronous in any state. It returns the block to IDLE immediately with the values above; no partial write completes.
- States: IDLE, ARM, SETTLE, WRITE, LAST, FINISH.
- IDLE: on iLoadReq go to ARM. iLoadReq in any other state is ignored.
- ARM: wait for iEnSample600k. A strobe in the same cycle as iLoadReq (while still in IDLE) is not used; the first strobe seen in ARM moves to SETTLE. oCoeffUpdateFlag=1 from that edge.
- SETTLE: down-counter loaded with SETTLE_CYC-1 and flag held high. When the count reaches 0, go to WRITE with oCoefReady=1 from the next edge.
- WRITE:
  - A handshake is iCoefValid & oCoefReady at a rising edge.
  - On a handshake at edge N: from edge N until edge N+1, oCsnRam=0, oWrnRam=0, oAddrRam = current {bank,local}, oWrDtRam = iCoefData.
  - With no handshake, oCsnRam and oWrnRam return to 1; address and data hold their last values.
  - Back-to-back handshakes give a continuous low on oCsnRam/oWrnRam.
- Address generation uses two counters, no divider:
  - local increments per write and wraps TAPS_PER_BANK-1 -> 0, incrementing bank.
  - NUM_TAPS=33 therefore yields addresses 0..9, 16..25, 32..41, 48..50.
- Tap counter 0..NUM_TAPS-1. On the handshake of tap NUM_TAPS-1, oCoefReady drops at the same edge and the state goes to LAST.
- LAST: final write is visible for this cycle only. Next edge: oCsnRam=oWrnRam=1, go to FINISH.
- FINISH: one cycle. oCoeffUpdateFlag=0 and oDone=1 from the FINISH->IDLE edge; oDone lasts one cycle.
- Update-flag framing: oCoeffUpdateFlag=1 strictly covers all RAM writes, with at least SETTLE_CYC leading cycles and at least one trailing cycle.
- iAbort: in ARM, SETTLE, WRITE or LAST, the next edge forces IDLE, oCsnRam=oWrnRam=1, flag=0, oCoefReady=0 and a one-cycle oAborted. A handshake coincident with iAbort is not written. iAbort in IDLE or FINISH is ignored.
- Counters are cleared on entry to ARM, so every load restarts at address 0.

Decomposition:
- Shared package fir_pkg: state encoding, NUM_TAPS / TAPS_PER_BANK / NUM_BANKS defaults, and a RAM-address field helper (bank bits [5:4], local bits [3:0]).
- One natural sub-module, fir_coeff_addr_gen: local/bank/tap counters with clear, increment, and last-tap flag.

Test Plan:
- Reset: hold iRsn=0 mid-clock -> all outputs at their reset values immediately, oCsnRam=1, oCoeffUpdateFlag=0.
- Full load, iCoefValid tied high, taps = Kaiser set (3,0,-6,...,500,...,3):
  - flag rises at the first strobe after iLoadReq;
  - first write exactly 25 clocks later;
  - 33 consecutive low cycles on oCsnRam/oWrnRam with address sequence 0..9, 16..25, 32..41, 48..50 and data matching;
  - oDone pulses once; flag low on the same edge.
- Gapped stream (iCoefValid toggling 1/0): oCsnRam low only on handshake cycles; addresses still contiguous; exactly 33 writes; data integrity preserved.
- iAbort asserted after tap 12 -> no further writes, flag=0, oAborted pulse. A subsequent load restarts at address 0 and completes with 33 writes.
- iLoadReq pulsed during SETTLE and WRITE -> ignored: single oDone, 33 writes total.
- iLoadReq coincident with iEnSample600k -> SETTLE entered only at the following strobe, 20 clocks later. Reset asserted mid-WRITE -> outputs return to reset values with no further RAM writes.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR coefficient loader.
// Holds FSM state encoding, geometry defaults and the RAM address packer.
package fir_pkg;

    localparam int C_NUM_TAPS      = 33;
    localparam int C_TAPS_PER_BANK = 10;
    localparam int C_NUM_BANKS     = 4;
    localparam int C_SETTLE_CYC    = 25;
    localparam int C_DATA_W        = 16;

    localparam int BANK_W  = 2;
    localparam int LOCAL_W = 4;
    localparam int ADDR_W  = BANK_W + LOCAL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SETTLE,
        ST_WRITE,
        ST_LAST,
        ST_FINISH
    } state_t;

    // RAM address layout: bank in [5:4], local tap index in [3:0].
    function automatic logic [ADDR_W-1:0] ram_addr(
        input logic [BANK_W-1:0]  bank,
        input logic [LOCAL_W-1:0] loc
    );
        return {bank, loc};
    endfunction

endpackage

// File: rtl/fir_coeff_load_ctrl_if.sv
// fir_coeff_load_ctrl_if: coefficient stream valid/ready handshake.
// Ports: coef_valid, coef_data (source->loader), coef_ready (loader->source).
interface fir_coeff_load_ctrl_if #(
    parameter int DATA_W = fir_pkg::C_DATA_W
);

    logic              coef_valid;
    logic [DATA_W-1:0] coef_data;
    logic              coef_ready;

    modport master (
        output coef_valid,
        output coef_data,
        input  coef_ready
    );

    modport slave (
        input  coef_valid,
        input  coef_data,
        output coef_ready
    );

endinterface

// File: rtl/fir_coeff_addr_gen.sv
// fir_coeff_addr_gen: local/bank/tap counters for the coefficient RAM.
// Ports: clk, rst_n, clr, inc in; addr {bank,local} and last_tap out.
module fir_coeff_addr_gen
    import fir_pkg::*;
#(
    parameter int NUM_TAPS      = C_NUM_TAPS,
    parameter int TAPS_PER_BANK = C_TAPS_PER_BANK,
    parameter int NUM_BANKS     = C_NUM_BANKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last_tap
);

    localparam int TAP_W = $clog2(NUM_TAPS);

    localparam logic [LOCAL_W-1:0] LOCAL_MAX = LOCAL_W'(TAPS_PER_BANK - 1);
    localparam logic [BANK_W-1:0]  BANK_MAX  = BANK_W'(NUM_BANKS - 1);
    localparam logic [TAP_W-1:0]   TAP_MAX   = TAP_W'(NUM_TAPS - 1);

    logic [LOCAL_W-1:0] loc;
    logic [BANK_W-1:0]  bank;
    logic [TAP_W-1:0]   tap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loc  <= '0;
            bank <= '0;
            tap  <= '0;
        end else if (clr) begin
            loc  <= '0;
            bank <= '0;
            tap  <= '0;
        end else if (inc) begin
            tap <= (tap == TAP_MAX) ? '0 : tap + 1'b1;
            // Local index wraps per bank; the bank counter carries.
            if (loc == LOCAL_MAX) begin
                loc  <= '0;
                bank <= (bank == BANK_MAX) ? '0 : bank + 1'b1;
            end else begin
                loc <= loc + 1'b1;
            end
        end
    end

    assign addr     = ram_addr(bank, loc);
    assign last_tap = (tap == TAP_MAX);

endmodule

// File: rtl/fir_coeff_load_ctrl.sv
// fir_coeff_load_ctrl: reloads FIR taps into the 4-bank SPSRAM.
// Ports: iClk12M, iRsn, iEnSample600k, iLoadReq, iAbort; coef stream
// (valid/data/ready); RAM write port oCsnRam/oWrnRam/oAddrRam/oWrDtRam;
// oCoeffUpdateFlag to the filter; status oBusy, oDone, oAborted.
module fir_coeff_load_ctrl
    import fir_pkg::*;
#(
    parameter int NUM_TAPS      = C_NUM_TAPS,
    parameter int TAPS_PER_BANK = C_TAPS_PER_BANK,
    parameter int NUM_BANKS     = C_NUM_BANKS,
    parameter int SETTLE_CYC    = C_SETTLE_CYC,
    parameter int DATA_W        = C_DATA_W
) (
    input  logic                        iClk12M,
    input  logic                        iRsn,
    input  logic                        iEnSample600k,
    input  logic                        iLoadReq,
    input  logic                        iAbort,
    fir_coeff_load_ctrl_if.slave        coef,
    output logic                        oCoeffUpdateFlag,
    output logic                        oCsnRam,
    output logic                        oWrnRam,
    output logic [ADDR_W-1:0]           oAddrRam,
    output logic [DATA_W-1:0]           oWrDtRam,
    output logic                        oBusy,
    output logic                        oDone,
    output logic                        oAborted
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

    state_t            state, state_d;
    logic [SET_W-1:0]  cnt, cnt_d;
    logic              ready_q, ready_d;
    logic              flag_q, flag_d;
    logic              csn_q, wrn_q, csn_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              abt_q, abt_d;
    logic              wr_ld;
    logic              clr, inc;
    logic              hs;
    logic [ADDR_W-1:0] gen_addr;
    logic              last_tap;

    fir_coeff_addr_gen #(
        .NUM_TAPS      (NUM_TAPS),
        .TAPS_PER_BANK (TAPS_PER_BANK),
        .NUM_BANKS     (NUM_BANKS)
    ) u_addr_gen (
        .clk      (iClk12M),
        .rst_n    (iRsn),
        .clr      (clr),
        .inc      (inc),
        .addr     (gen_addr),
        .last_tap (last_tap)
    );

    assign hs = coef.coef_valid & ready_q;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ready_d = ready_q;
        flag_d  = flag_q;
        csn_d   = 1'b1;
        done_d  = 1'b0;
        abt_d   = 1'b0;
        wr_ld   = 1'b0;
        clr     = 1'b0;
        inc     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (iLoadReq) begin
                    state_d = ST_ARM;
                    clr     = 1'b1;
                end
            end
            ST_ARM: begin
                if (iEnSample600k) begin
                    state_d = ST_SETTLE;
                    flag_d  = 1'b1;
                    cnt_d   = SET_LOAD;
                end
            end
            ST_SETTLE: begin
                // Ready rises as the count hits zero, so the first
                // write lands SETTLE_CYC clocks after the flag rose.
                if (cnt <= SET_W'(1)) begin
                    state_d = ST_WRITE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_WRITE: begin
                if (hs) begin
                    csn_d = 1'b0;
                    wr_ld = 1'b1;
                    inc   = 1'b1;
                    if (last_tap) begin
                        ready_d = 1'b0;
                        state_d = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                flag_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort wins over any coincident handshake.
        if (iAbort &&
            state inside {ST_ARM, ST_SETTLE, ST_WRITE, ST_LAST}) begin
            state_d = ST_IDLE;
            flag_d  = 1'b0;
            ready_d = 1'b0;
            csn_d   = 1'b1;
            abt_d   = 1'b1;
            wr_ld   = 1'b0;
            inc     = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            flag_q  <= 1'b0;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ready_q <= ready_d;
            flag_q  <= flag_d;
            csn_q   <= csn_d;
            wrn_q   <= csn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
            if (wr_ld) begin
                addr_q <= gen_addr;
                data_q <= coef.coef_data;
            end
        end
    end

    assign coef.coef_ready  = ready_q;
    assign oCoeffUpdateFlag = flag_q;
    assign oCsnRam          = csn_q;
    assign oWrnRam          = wrn_q;
    assign oAddrRam         = addr_q;
    assign oWrDtRam         = data_q;
    assign oBusy            = busy_q;
    assign oDone            = done_q;
    assign oAborted         = abt_q;

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// tb_fir_coeff_load_ctrl: directed bench for the FIR coefficient loader.
// Drives loads, watches the RAM write port and checks against a model.
`timescale 1ns/1ps
module tb_fir_coeff_load_ctrl;

    localparam int NT = 33;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        strobe   = 1'b0;
    logic        load_req = 1'b0;
    logic        abort    = 1'b0;
    logic        flag, csn, wrn, busy, done, aborted;
    logic [5:0]  addr;
    logic [15:0] wdata;

    fir_coeff_load_ctrl_if #(.DATA_W(16)) cif();

    fir_coeff_load_ctrl dut (
        .iClk12M          (clk),
        .iRsn             (rst_n),
        .iEnSample600k    (strobe),
        .iLoadReq         (load_req),
        .iAbort           (abort),
        .coef             (cif),
        .oCoeffUpdateFlag (flag),
        .oCsnRam          (csn),
        .oWrnRam          (wrn),
        .oAddrRam         (addr),
        .oWrDtRam         (wdata),
        .oBusy            (busy),
        .oDone            (done),
        .oAborted         (aborted)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int req_cyc     = 0;
    int wr_seen, first_wr, last_wr;
    int flag_rise, flag_fall, done_cnt, done_cyc, abort_cnt;
    bit flag_q      = 1'b0;
    bit gapped      = 1'b0;
    bit stream_on   = 1'b0;

    logic [15:0] cur [NT];
    int h [17] = '{3, 0, -6, -9, 0, 15, 22, 0, -35, -48,
                   0, 70, 94, 0, -140, -210, 500};

    function automatic logic [5:0] exp_addr(input int i);
        logic [1:0] b;
        logic [3:0] l;
        b = 2'(i / 10);
        l = 4'(i % 10);
        return {b, l};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (csn === 1'b0) begin
            chk("wr_en", wrn, 0);
            chk("wr_flag", flag, 1);
            if (wr_seen < NT) begin
                chk($sformatf("addr%0d", wr_seen), addr, exp_addr(wr_seen));
                chk($sformatf("data%0d", wr_seen), wdata, cur[wr_seen]);
            end
            if (wr_seen == 0) first_wr = cyc;
            last_wr = cyc;
            wr_seen++;
        end
        if (flag === 1'b1 && !flag_q) flag_rise = cyc;
        if (flag === 1'b0 && flag_q) flag_fall = cyc;
        flag_q = (flag === 1'b1);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (aborted === 1'b1) abort_cnt++;
        strobe = (cyc % 20 == 0);
        cif.coef_valid = gapped ? ~cif.coef_valid : stream_on;
        cif.coef_data  = cur[(wr_seen < NT) ? wr_seen : NT - 1];
    endtask

    task automatic start_load(input int phase);
        for (int i = 0; i < 20 && (cyc % 20) != phase; i++) tick();
        wr_seen   = 0;
        first_wr  = -1;
        last_wr   = -1;
        flag_rise = -1;
        flag_fall = -1;
        done_cnt  = 0;
        done_cyc  = -1;
        abort_cnt = 0;
        load_req  = 1'b1;
        req_cyc   = cyc;
        tick();
        load_req  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
        chk(tag, done_cnt, 1);
    endtask

    task automatic wait_writes(input string tag, input int n);
        for (int i = 0; i < 400 && wr_seen < n; i++) tick();
        chk(tag, wr_seen, n);
    endtask

    initial begin
        cif.coef_valid = 1'b0;
        cif.coef_data  = '0;
        for (int i = 0; i < NT; i++) cur[i] = 16'(h[(i <= 16) ? i : 32 - i]);

        // Reset state
        repeat (3) tick();
        chk("rst_flag", flag, 0);
        chk("rst_csn", csn, 1);
        chk("rst_wrn", wrn, 1);
        chk("rst_addr", addr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_ready", cif.coef_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abort", aborted, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Load 1: Kaiser taps, valid tied high
        stream_on      = 1'b1;
        cif.coef_valid = 1'b1;
        start_load(5);
        chk("arm_busy", busy, 1);
        chk("arm_flag", flag, 0);
        wait_done("l1_done");
        repeat (3) tick();
        chk("l1_rise", flag_rise - req_cyc, 16);
        chk("l1_first", first_wr - flag_rise, 25);
        chk("l1_nwr", wr_seen, 33);
        chk("l1_span", last_wr - first_wr, 32);
        chk("l1_ndone", done_cnt, 1);
        chk("l1_fall_done", flag_fall, done_cyc);
        chk("l1_trail", flag_fall - last_wr, 2);
        chk("l1_busy", busy, 0);
        chk("l1_ready", cif.coef_ready, 0);

        // Load 2: gapped stream
        for (int i = 0; i < NT; i++) cur[i] = 16'(i * 97 - 1500);
        gapped = 1'b1;
        start_load(5);
        wait_done("l2_done");
        repeat (3) tick();
        chk("l2_nwr", wr_seen, 33);
        chk("l2_span", last_wr - first_wr, 64);
        chk("l2_ndone", done_cnt, 1);
        gapped         = 1'b0;
        cif.coef_valid = 1'b1;

        // Load 3: abort after tap 12, then a clean reload
        for (int i = 0; i < NT; i++) cur[i] = 16'(16384 + i * 3);
        start_load(5);
        wait_writes("l3_reach", 13);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_pulse", aborted, 1);
        chk("ab_flag", flag, 0);
        chk("ab_csn", csn, 1);
        chk("ab_ready", cif.coef_ready, 0);
        chk("ab_busy", busy, 0);
        repeat (30) tick();
        chk("ab_nwr", wr_seen, 13);
        chk("ab_npulse", abort_cnt, 1);
        chk("ab_nodone", done_cnt, 0);
        start_load(5);
        wait_done("l3b_done");
        repeat (3) tick();
        chk("l3b_nwr", wr_seen, 33);
        chk("l3b_noabort", abort_cnt, 0);

        // Load 4: stray load requests in SETTLE and WRITE
        for (int i = 0; i < NT; i++) cur[i] = 16'(31000 - i * 1001);
        start_load(5);
        repeat (20) tick();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_writes("l4_reach", 5);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_done("l4_done");
        repeat (30) tick();
        chk("l4_nwr", wr_seen, 33);
        chk("l4_ndone", done_cnt, 1);
        chk("l4_busy", busy, 0);
        chk("l4_flag", flag, 0);

        // Load 5: request coincident with strobe, reset mid-write
        start_load(0);
        wait_writes("l5_reach", 5);
        chk("l5_rise", flag_rise - req_cyc, 21);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_flag", flag, 0);
        chk("mr_csn", csn, 1);
        chk("mr_wrn", wrn, 1);
        chk("mr_addr", addr, 0);
        chk("mr_data", wdata, 0);
        chk("mr_ready", cif.coef_ready, 0);
        chk("mr_busy", busy, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("mr_nwr", wr_seen, 5);
        chk("mr_idle", busy, 0);
        chk("mr_nodone", done_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
